// File: rtl/pulse_period_monitor.sv
// pulse_period_monitor
// Per-channel period measurement and lock detection for periodic strobes that
// are already synchronous to aclk. Each channel measures rising-edge to
// rising-edge distance, locks after LOCK_COUNT consecutive in-tolerance
// periods and raises a sticky error on loss of lock or loss of pulses.
// Optional min/max period statistics are built when PULSE_MON_STATS_EN is
// defined; the default build leaves them out entirely.
module pulse_period_monitor #(
  parameter int          NCH        = 4,
  parameter int          CNT_W      = 24,
  parameter int unsigned MAX_PERIOD = 2**24-1,
  parameter int          TOL        = 1,
  parameter int          LOCK_COUNT = 4
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   enable_i,
  input  logic                   clear_i,
  input  logic [NCH-1:0]         pulse_i,
  output logic [NCH*CNT_W-1:0]   period_o,
  output logic [NCH-1:0]         locked_o,
  output logic [NCH-1:0]         error_o,
  output logic [NCH-1:0]         edge_o
`ifdef PULSE_MON_STATS_EN
  ,
  output logic [NCH*CNT_W-1:0]   period_min_o,
  output logic [NCH*CNT_W-1:0]   period_max_o
`endif
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MEASURE = 2'd1;
  localparam logic [1:0] S_TRACK   = 2'd2;
  localparam logic [1:0] S_LOCKED  = 2'd3;

  localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0]      CNT_TMO = CNT_W'(MAX_PERIOD - 1);
  localparam logic signed [CNT_W:0] TOL_S   = (CNT_W+1)'(TOL);
  localparam logic [7:0]            LOCK_N  = 8'(LOCK_COUNT);

  // Counter increment that parks at MAX_PERIOD instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  // |p - r| <= TOL, evaluated one bit wider than the counter so it cannot wrap.
  function automatic logic in_tol(input logic [CNT_W-1:0] p,
                                  input logic [CNT_W-1:0] r);
    logic signed [CNT_W:0] d;
    d = $signed({1'b0, p}) - $signed({1'b0, r});
    if (d[CNT_W]) d = -d;
    return (d <= TOL_S);
  endfunction

  logic [1:0]       state [NCH];
  logic [CNT_W-1:0] cnt   [NCH];
  logic [CNT_W-1:0] ref_p [NCH];
  logic [7:0]       match [NCH];
  logic [NCH-1:0]   prev;

  logic [CNT_W-1:0] p_cur [NCH];
  logic [NCH-1:0]   det;
  logic [NCH-1:0]   tol_ok;
  logic [NCH-1:0]   tracking;
  logic [NCH-1:0]   tmo;
  logic [NCH-1:0]   set_err;

  // Edge detect, current period, tolerance test, timeout and error-set terms.
  always_comb begin
    det      = pulse_i & ~prev;
    tol_ok   = '0;
    tracking = '0;
    tmo      = '0;
    set_err  = '0;
    for (int n = 0; n < NCH; n++) begin
      p_cur[n]    = cnt[n] + CNT_W'(1);
      tol_ok[n]   = in_tol(p_cur[n], ref_p[n]);
      tracking[n] = (state[n] == S_TRACK) || (state[n] == S_LOCKED);
      tmo[n]      = (state[n] != S_IDLE) && (cnt[n] == CNT_TMO) && !det[n];
      set_err[n]  = enable_i &&
                    ((det[n] && (state[n] == S_LOCKED) && !tol_ok[n]) ||
                     (tmo[n] && tracking[n]));
    end
  end

  // Per-channel counter and lock state machine; disable parks channels idle.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      prev     <= '0;
      edge_o   <= '0;
      locked_o <= '0;
      period_o <= '0;
      for (int n = 0; n < NCH; n++) begin
        state[n] <= S_IDLE;
        cnt[n]   <= '0;
        ref_p[n] <= '0;
        match[n] <= '0;
      end
    end else begin
      prev <= pulse_i;
      for (int n = 0; n < NCH; n++) begin
        if (!enable_i) begin
          state[n]    <= S_IDLE;
          cnt[n]      <= '0;
          match[n]    <= '0;
          locked_o[n] <= 1'b0;
          edge_o[n]   <= 1'b0;
        end else begin
          edge_o[n] <= det[n];
          cnt[n]    <= det[n] ? '0 : sat_inc(cnt[n]);
          case (state[n])
            S_IDLE: begin
              if (det[n]) state[n] <= S_MEASURE;
            end
            S_MEASURE: begin
              if (det[n]) begin
                period_o[n*CNT_W +: CNT_W] <= p_cur[n];
                ref_p[n] <= p_cur[n];
                match[n] <= '0;
                state[n] <= S_TRACK;
              end else if (tmo[n]) begin
                state[n] <= S_IDLE;
              end
            end
            S_TRACK: begin
              if (det[n]) begin
                period_o[n*CNT_W +: CNT_W] <= p_cur[n];
                if (tol_ok[n]) begin
                  match[n] <= match[n] + 8'd1;
                  if (match[n] + 8'd1 == LOCK_N) begin
                    state[n]    <= S_LOCKED;
                    locked_o[n] <= 1'b1;
                  end
                end else begin
                  ref_p[n] <= p_cur[n];
                  match[n] <= '0;
                end
              end else if (tmo[n]) begin
                state[n] <= S_IDLE;
              end
            end
            S_LOCKED: begin
              if (det[n]) begin
                period_o[n*CNT_W +: CNT_W] <= p_cur[n];
                if (!tol_ok[n]) begin
                  locked_o[n] <= 1'b0;
                  ref_p[n]    <= p_cur[n];
                  match[n]    <= '0;
                  state[n]    <= S_TRACK;
                end
              end else if (tmo[n]) begin
                locked_o[n] <= 1'b0;
                state[n]    <= S_IDLE;
              end
            end
            default: state[n] <= S_IDLE;
          endcase
        end
      end
    end
  end

  // Sticky error bits: a new error in the same cycle as clear_i wins.
  always_ff @(posedge aclk) begin
    if (!aresetn) error_o <= '0;
    else          error_o <= (error_o & ~{NCH{clear_i}}) | set_err;
  end

`ifdef PULSE_MON_STATS_EN
  // Running min/max of every period measured while tracking or locked.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      period_min_o <= '1;
      period_max_o <= '0;
    end else begin
      for (int n = 0; n < NCH; n++) begin
        if (enable_i && det[n] && tracking[n]) begin
          if (clear_i || (p_cur[n] < period_min_o[n*CNT_W +: CNT_W]))
            period_min_o[n*CNT_W +: CNT_W] <= p_cur[n];
          if (clear_i || (p_cur[n] > period_max_o[n*CNT_W +: CNT_W]))
            period_max_o[n*CNT_W +: CNT_W] <= p_cur[n];
        end else if (clear_i) begin
          period_min_o[n*CNT_W +: CNT_W] <= '1;
          period_max_o[n*CNT_W +: CNT_W] <= '0;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_pulse_period_monitor.sv
// tb_pulse_period_monitor
// Scoreboard bench for pulse_period_monitor. A timestamp-based reference
// model predicts each cycle's status and each reported period; a separate
// monitor process pops and compares. Define PULSE_MON_STATS_EN to also
// cover the min/max statistics outputs.
module tb_pulse_period_monitor;

  localparam int NCH        = 4;
  localparam int CNT_W      = 10;
  localparam int MAX_PERIOD = 200;
  localparam int TOL        = 1;
  localparam int LOCK_COUNT = 4;
  localparam int ALL1       = (1 << CNT_W) - 1;

  logic                 aclk = 1'b0;
  logic                 aresetn;
  logic                 enable_i;
  logic                 clear_i;
  logic [NCH-1:0]       pulse_i;
  logic [NCH*CNT_W-1:0] period_o;
  logic [NCH-1:0]       locked_o;
  logic [NCH-1:0]       error_o;
  logic [NCH-1:0]       edge_o;
`ifdef PULSE_MON_STATS_EN
  logic [NCH*CNT_W-1:0] period_min_o;
  logic [NCH*CNT_W-1:0] period_max_o;
`endif

  pulse_period_monitor #(
    .NCH(NCH), .CNT_W(CNT_W), .MAX_PERIOD(MAX_PERIOD),
    .TOL(TOL), .LOCK_COUNT(LOCK_COUNT)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .enable_i(enable_i), .clear_i(clear_i),
    .pulse_i(pulse_i), .period_o(period_o), .locked_o(locked_o),
    .error_o(error_o), .edge_o(edge_o)
`ifdef PULSE_MON_STATS_EN
    , .period_min_o(period_min_o), .period_max_o(period_max_o)
`endif
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic                 rst;
    logic [NCH-1:0]       edg;
    logic [NCH-1:0]       lck;
    logic [NCH-1:0]       err;
    logic [NCH*CNT_W-1:0] per;
    logic [NCH*CNT_W-1:0] mn;
    logic [NCH*CNT_W-1:0] mx;
  } exp_t;

  typedef struct {
    int ch;
    int per;
  } pexp_t;

  exp_t  sq[$];
  pexp_t pq[$];
  int    checks   = 0;
  int    failures = 0;

  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // ---------------- reference model (timestamps and edge counts) ----------
  int t = 0;
  int m_nedge [NCH];   // edges seen since the channel last went idle (capped at 2)
  int m_last  [NCH];   // timestamp of last accepted edge
  int m_ref   [NCH];
  int m_run   [NCH];   // consecutive in-tolerance periods
  int m_per   [NCH];
  int m_mn    [NCH];
  int m_mx    [NCH];
  bit m_lck   [NCH];
  bit m_err   [NCH];
  bit m_prev  [NCH];

  function automatic void model_step(input logic en, input logic clr,
                                     input logic rstn, input logic [NCH-1:0] pv);
    exp_t e;
    int   p, d;
    bit   det, seterr;
    t++;
    e.rst = !rstn;
    e.edg = '0;
    for (int c = 0; c < NCH; c++) begin
      if (!rstn) begin
        m_nedge[c] = 0; m_last[c] = 0; m_ref[c] = 0; m_run[c] = 0;
        m_per[c] = 0; m_mn[c] = ALL1; m_mx[c] = 0;
        m_lck[c] = 0; m_err[c] = 0; m_prev[c] = 0;
      end else begin
        det = pv[c] && !m_prev[c];
        m_prev[c] = pv[c];
        seterr = 0;
        if (clr) begin m_mn[c] = ALL1; m_mx[c] = 0; end
        if (!en) begin
          m_nedge[c] = 0; m_run[c] = 0; m_lck[c] = 0;
        end else if (det) begin
          e.edg[c] = 1'b1;
          if (m_nedge[c] == 0) begin
            m_nedge[c] = 1; m_last[c] = t;
          end else begin
            p = t - m_last[c];
            m_last[c] = t;
            m_per[c] = p;
            if (m_nedge[c] == 1) begin
              m_ref[c] = p; m_run[c] = 0; m_nedge[c] = 2;
            end else begin
              if (p < m_mn[c]) m_mn[c] = p;
              if (p > m_mx[c]) m_mx[c] = p;
              d = p - m_ref[c];
              if (d < 0) d = -d;
              if (d <= TOL) begin
                if (!m_lck[c]) begin
                  m_run[c]++;
                  if (m_run[c] == LOCK_COUNT) m_lck[c] = 1;
                end
              end else begin
                if (m_lck[c]) seterr = 1;
                m_lck[c] = 0; m_ref[c] = p; m_run[c] = 0;
              end
            end
          end
          pq.push_back('{c, m_per[c]});
        end else if (m_nedge[c] >= 1 && (t - m_last[c]) == MAX_PERIOD) begin
          seterr = (m_nedge[c] >= 2);
          m_nedge[c] = 0; m_lck[c] = 0;
        end
        m_err[c] = (m_err[c] && !clr) || seterr;
      end
      e.lck[c] = m_lck[c];
      e.err[c] = m_err[c];
      e.per[c*CNT_W +: CNT_W] = CNT_W'(m_per[c]);
      e.mn[c*CNT_W +: CNT_W]  = CNT_W'(m_mn[c]);
      e.mx[c*CNT_W +: CNT_W]  = CNT_W'(m_mx[c]);
    end
    sq.push_back(e);
  endfunction

  // ---------------- strobe generators ----------------
  int g_on   [NCH];
  int g_pos  [NCH];
  int g_per  [NCH];
  int g_base [NCH];
  int g_jit  [NCH];
  int g_hi   [NCH];
  int fq     [NCH][$];   // forced period sequence, consumed before base/jitter
  int arm_cnt  = 0;      // clear on the Nth rising edge of ch0, then once more
  bit clr_pend = 0;
  bit tb_prev0 = 0;

  function automatic int next_per(input int c);
    if (fq[c].size() != 0) return fq[c].pop_front();
    return g_base[c] + int'($urandom_range(0, g_jit[c]));
  endfunction

  function automatic void gen_start(input int c, input int base, input int jit,
                                    input int hi);
    g_on[c] = 1; g_base[c] = base; g_jit[c] = jit; g_hi[c] = hi;
    g_pos[c] = 0; g_per[c] = next_per(c);
  endfunction

  task automatic cyc(input logic en, input logic clr, input logic rstn);
    logic [NCH-1:0] pv;
    logic           c_clr;
    @(negedge aclk);
    pv = '0;
    for (int c = 0; c < NCH; c++) begin
      if (g_on[c] != 0) begin
        pv[c] = (g_pos[c] < g_hi[c]);
        g_pos[c]++;
        if (g_pos[c] >= g_per[c]) begin
          g_pos[c] = 0;
          g_per[c] = next_per(c);
        end
      end
    end
    c_clr = clr;
    if (clr_pend) begin
      c_clr = 1'b1; clr_pend = 1'b0;
    end else if (pv[0] && !tb_prev0 && arm_cnt > 0) begin
      arm_cnt--;
      if (arm_cnt == 0) begin c_clr = 1'b1; clr_pend = 1'b1; end
    end
    tb_prev0 = pv[0];
    aresetn  = rstn;
    enable_i = en;
    clear_i  = c_clr;
    pulse_i  = pv;
    model_step(en, c_clr, rstn, pv);
  endtask

  task automatic run(input int n);
    repeat (n) cyc(1'b1, 1'b0, 1'b1);
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t  e;
    pexp_t p;
    forever begin
      @(posedge aclk);
      #1;
      if (sq.size() != 0) begin
        e = sq.pop_front();
        chk("edge_o", 64'(edge_o), 64'(e.edg));
        chk("locked_o", 64'(locked_o), 64'(e.lck));
        chk("error_o", 64'(error_o), 64'(e.err));
        if (e.rst) chk("period_o_reset", 64'(period_o), 64'(e.per));
`ifdef PULSE_MON_STATS_EN
        chk("period_min_o", 64'(period_min_o), 64'(e.mn));
        chk("period_max_o", 64'(period_max_o), 64'(e.mx));
`endif
        for (int c = 0; c < NCH; c++) begin
          if (edge_o[c]) begin
            checks++;
            if (pq.size() == 0) begin
              failures++;
              $display("FAIL period_queue_ch%0d actual=empty required=entry", c);
            end else begin
              p = pq.pop_front();
              chk($sformatf("period_ch%0d", c),
                  64'(period_o[c*CNT_W +: CNT_W]), 64'(p.per));
              chk($sformatf("period_chan_id%0d", c), 64'(c), 64'(p.ch));
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    aresetn = 1'b0; enable_i = 1'b0; clear_i = 1'b0; pulse_i = '0;
    for (int c = 0; c < NCH; c++) begin
      g_on[c] = 0; g_pos[c] = 0; g_per[c] = 1; g_base[c] = 1; g_jit[c] = 0; g_hi[c] = 1;
    end

    repeat (3) cyc(1'b0, 1'b0, 1'b0);

    // basic lock on ch0, period 64
    gen_start(0, 64, 0, 1);
    run(64 * 8);

    // 64/65 alternation stays locked, then a 67 breaks lock and relocks
    g_jit[0] = 1;
    run(64 * 8 + 20);
    g_base[0] = 67; g_jit[0] = 0;
    run(67 * 8);

    // clear_i coincides with a mismatch, then clear_i alone
    g_base[0] = 80; arm_cnt = 2;
    run(80 * 3);
    run(80 * 6);

    // timeout after lock
    g_on[0] = 0;
    run(260);

    // edge exactly at MAX_PERIOD, then one period too long
    gen_start(1, 60, 0, 1);
    run(60 * 8);
    fq[1].push_back(200); fq[1].push_back(200); fq[1].push_back(201);
    run(60 + 200 + 200 + 201 + 60 * 3);
    g_base[1] = 199; g_jit[1] = 2;
    run(1200);
    g_on[1] = 0;

    // enable drop while strobe held high, re-enable while still high
    gen_start(2, 30, 0, 20);
    run(100);
    for (int i = 0; i < 60; i++) begin
      if (pulse_i[2] && g_pos[2] == 1) break;
      cyc(1'b1, 1'b0, 1'b1);
    end
    repeat (3) cyc(1'b0, 1'b0, 1'b1);
    run(30 * 8);

    // one-cycle reset mid-run
    cyc(1'b1, 1'b0, 1'b0);
    run(100);

    // statistics: periods 100, 100, 98, 103 then a clear
    for (int c = 0; c < NCH; c++) g_on[c] = 0;
    cyc(1'b1, 1'b0, 1'b0);
    fq[3].push_back(100); fq[3].push_back(100);
    fq[3].push_back(98);  fq[3].push_back(103);
    gen_start(3, 90, 0, 1);
    run(100 + 100 + 98 + 103 + 10);
    cyc(1'b1, 1'b1, 1'b1);
    run(200);

    // randomized run on all channels
    for (int blk = 0; blk < 6; blk++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 3) == 0) g_on[c] = 0;
        else gen_start(c, int'($urandom_range(20, 90)), int'($urandom_range(0, 2)),
                       int'($urandom_range(1, 5)));
      end
      for (int i = 0; i < 500; i++)
        cyc(logic'($urandom_range(0, 299) != 0),
            logic'($urandom_range(0, 63) == 0),
            logic'($urandom_range(0, 1999) != 0));
    end

    run(3);
    @(posedge aclk);
    #2;
    chk("scoreboard_drained", 64'(sq.size()), 64'd0);
    chk("period_queue_drained", 64'(pq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
